// File: rtl/setup_param_pkg.sv
`default_nettype none
// ============================================================================
// Package     : Tipos
// Description : Shared lock types, digit markers, factory defaults and helpers
//               used by the setup menu and its keypad decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package Tipos;

    localparam int NUM_SENHAS_MAX = 8;
    localparam int N_DIG          = 20;

    localparam logic [3:0] DIG_EMPTY = 4'hF;
    localparam logic [3:0] DIG_FIM   = 4'hB;

    // digits[0] is the most recently typed digit
    typedef struct packed {
        logic [N_DIG-1:0][3:0] digits;
    } senhaPac_t;

    typedef struct packed {
        logic [3:0] BCD5;
        logic [3:0] BCD4;
        logic [3:0] BCD3;
        logic [3:0] BCD2;
        logic [3:0] BCD1;
        logic [3:0] BCD0;
    } bcdPac_t;

    typedef struct packed {
        logic                                bip_status;
        logic [6:0]                          bip_time;
        logic [6:0]                          tranca_aut_time;
        senhaPac_t                           senha_master;
        senhaPac_t [NUM_SENHAS_MAX-1:0]      senha;
    } setupPac_t;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_AUTH     = 4'd1,
        ST_HAB_BIP  = 4'd2,
        ST_T_BIP    = 4'd3,
        ST_T_TRC    = 4'd4,
        ST_S_MASTER = 4'd5,
        ST_S_USER   = 4'd6,
        ST_SAVE     = 4'd7,
        ST_ABORT    = 4'd8
    } setup_state_t;

    localparam senhaPac_t c_SENHA_VAZIA = senhaPac_t'({N_DIG{DIG_EMPTY}});
    localparam bcdPac_t   c_BCD_BLANK   = bcdPac_t'({6{DIG_EMPTY}});

    // Factory: bip on, 5 s bip, 5 s auto-lock, master 1234, no user passwords
    localparam setupPac_t c_SETUP_DEFAULT = setupPac_t'({
        1'b1,
        7'd5,
        7'd5,
        {{(N_DIG-4){DIG_EMPTY}}, 16'h1234},
        {NUM_SENHAS_MAX{c_SENHA_VAZIA}}
    });

    function automatic logic dig_is_bad(input logic [3:0] d);
        return (d >= 4'hA) && (d <= 4'hE);
    endfunction

    function automatic senhaPac_t senha_trim(input senhaPac_t s, input logic [4:0] len);
        senhaPac_t r;
        for (int i = 0; i < N_DIG; i++) begin
            r.digits[i] = (5'(i) < len) ? s.digits[i] : DIG_EMPTY;
        end
        return r;
    endfunction

    function automatic logic [6:0] clamp7(input logic [6:0] v,
                                          input logic [6:0] lo,
                                          input logic [6:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        return 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_units(input logic [6:0] v);
        return 4'(v % 7'd10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/setup_param_digitos_dec.sv
`default_nettype none
// ============================================================================
// Module      : setup_digitos_dec
// Description : Combinational classifier for one keypad entry: skip/finish
//               keys, typed length, illegal digits and two-digit value.
// Revision    : 1.0 - initial release
// ============================================================================
module setup_digitos_dec
    import Tipos::*;
(
    input  senhaPac_t   digitos_value,
    output logic        is_skip,
    output logic        is_fim,
    output logic [4:0]  len,
    output logic        has_bad,
    output logic [6:0]  val2
);

    logic [N_DIG-1:0] w_is_empty;
    logic [N_DIG-1:0] w_is_fim;
    logic [N_DIG-1:0] w_is_bad;
    logic             w_run;
    logic [3:0]       w_d0;
    logic [3:0]       w_d1;

    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_dig
        assign w_is_empty[gi] = (digitos_value.digits[gi] == DIG_EMPTY);
        assign w_is_fim[gi]   = (digitos_value.digits[gi] == DIG_FIM);
        assign w_is_bad[gi]   = dig_is_bad(digitos_value.digits[gi]);
    end

    assign is_skip = &w_is_empty;
    assign is_fim  = &w_is_fim;

    // Length stops at the first empty position; bad digits only count inside it
    always_comb begin
        len     = 5'd0;
        has_bad = 1'b0;
        w_run   = 1'b1;
        for (int i = 0; i < N_DIG; i++) begin
            if (w_run && !w_is_empty[i]) begin
                len = len + 5'd1;
                if (w_is_bad[i]) begin
                    has_bad = 1'b1;
                end
            end else begin
                w_run = 1'b0;
            end
        end
    end

    assign w_d0 = w_is_empty[0] ? 4'd0 : digitos_value.digits[0];
    assign w_d1 = w_is_empty[1] ? 4'd0 : digitos_value.digits[1];
    assign val2 = 7'(w_d1) * 7'd10 + 7'(w_d0);

endmodule
`default_nettype wire

// File: rtl/setup_param.sv
`default_nettype none
// ============================================================================
// Module      : setup_param
// Description : Master-protected configuration menu that edits bip, times and
//               passwords, returning the edited configuration on save.
// Revision    : 1.0 - initial release
// ============================================================================
module setup_param
    import Tipos::*;
#(
    parameter int N_SENHAS    = 4,
    parameter int MIN_DIG     = 4,
    parameter int MAX_DIG     = 12,
    parameter int T_MIN       = 5,
    parameter int T_MAX       = 60,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 30_000_000
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        setup_on,
    input  setupPac_t   setup_cur,
    input  senhaPac_t   digitos_value,
    input  logic        digitos_valid,
    output logic        display_en,
    output bcdPac_t     bcd_pac,
    output setupPac_t   data_setup_new,
    output logic        data_setup_ok,
    output logic        setup_abort,
    output logic        setup_err
);

    localparam int c_TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int c_TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES + 1) : 1;
    localparam int c_IDX_W = $clog2(NUM_SENHAS_MAX);

    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TRY_W-1:0] c_TRY_LAST = c_TRY_W'(MAX_TRIES - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_SENHAS - 1);

    setup_state_t          r_state,  w_state_nxt;
    setupPac_t             r_work,   w_work_nxt;
    logic [c_IDX_W-1:0]    r_idx,    w_idx_nxt;
    logic [c_TRY_W-1:0]    r_tries,  w_tries_nxt;
    logic [c_TMR_W-1:0]    r_timer,  w_timer_nxt;
    logic                  r_err,    w_err_nxt;
    logic                  w_adv;

    logic                  w_is_skip;
    logic                  w_is_fim;
    logic [4:0]            w_len;
    logic                  w_has_bad;
    logic [6:0]            w_val2;

    logic [3:0]            w_d0;
    logic                  w_time_bad;
    logic [6:0]            w_time_val;
    logic                  w_pw_ok;
    senhaPac_t             w_pw_new;
    logic                  w_master_hit;
    logic [3:0]            w_user_step;

    setup_digitos_dec u_dec (
        .digitos_value (digitos_value),
        .is_skip       (w_is_skip),
        .is_fim        (w_is_fim),
        .len           (w_len),
        .has_bad       (w_has_bad),
        .val2          (w_val2)
    );

    assign w_d0         = digitos_value.digits[0];
    assign w_time_bad   = dig_is_bad(digitos_value.digits[0]) | dig_is_bad(digitos_value.digits[1]);
    assign w_time_val   = clamp7(w_val2, 7'(T_MIN), 7'(T_MAX));
    assign w_pw_ok      = (w_len >= 5'(MIN_DIG)) && (w_len <= 5'(MAX_DIG)) && !w_has_bad;
    assign w_pw_new     = senha_trim(digitos_value, w_len);
    assign w_master_hit = !w_is_skip && !w_is_fim && (digitos_value == r_work.senha_master);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_work  <= c_SETUP_DEFAULT;
            r_idx   <= '0;
            r_tries <= '0;
            r_timer <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_idx   <= w_idx_nxt;
            r_tries <= w_tries_nxt;
            r_timer <= w_timer_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_idx_nxt   = r_idx;
        w_tries_nxt = r_tries;
        w_timer_nxt = r_timer;
        w_err_nxt   = 1'b0;
        w_adv       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (setup_on) begin
                    w_work_nxt  = setup_cur;
                    w_tries_nxt = '0;
                    w_timer_nxt = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_AUTH;
                end
            end
            ST_SAVE, ST_ABORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                // A strobe always clears the timer, even on the expiry cycle
                if (digitos_valid) begin
                    w_timer_nxt = '0;
                    if (r_state == ST_AUTH) begin
                        if (w_master_hit) begin
                            w_state_nxt = ST_HAB_BIP;
                        end else begin
                            w_err_nxt = 1'b1;
                            if (r_tries == c_TRY_LAST) begin
                                w_state_nxt = ST_ABORT;
                            end else begin
                                w_tries_nxt = r_tries + 1'b1;
                            end
                        end
                    end else if (w_is_skip) begin
                        w_adv = 1'b1;
                    end else if (w_is_fim) begin
                        w_state_nxt = ST_SAVE;
                    end else begin
                        case (r_state)
                            ST_HAB_BIP: begin
                                if (w_d0 <= 4'd1) begin
                                    w_work_nxt.bip_status = w_d0[0];
                                    w_adv = 1'b1;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            ST_T_BIP: begin
                                if (w_time_bad) begin
                                    w_err_nxt = 1'b1;
                                end else begin
                                    w_work_nxt.bip_time = w_time_val;
                                    w_adv = 1'b1;
                                end
                            end
                            ST_T_TRC: begin
                                if (w_time_bad) begin
                                    w_err_nxt = 1'b1;
                                end else begin
                                    w_work_nxt.tranca_aut_time = w_time_val;
                                    w_adv = 1'b1;
                                end
                            end
                            ST_S_MASTER: begin
                                if (w_pw_ok) begin
                                    w_work_nxt.senha_master = w_pw_new;
                                    w_adv = 1'b1;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            ST_S_USER: begin
                                if (w_pw_ok) begin
                                    w_work_nxt.senha[r_idx] = w_pw_new;
                                    w_adv = 1'b1;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end else if (r_timer == c_TMR_LAST) begin
                    w_state_nxt = ST_ABORT;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end

                if (w_adv) begin
                    case (r_state)
                        ST_HAB_BIP:  w_state_nxt = ST_T_BIP;
                        ST_T_BIP:    w_state_nxt = ST_T_TRC;
                        ST_T_TRC:    w_state_nxt = ST_S_MASTER;
                        ST_S_MASTER: begin
                            w_state_nxt = ST_S_USER;
                            w_idx_nxt   = '0;
                        end
                        ST_S_USER: begin
                            if (r_idx == c_IDX_LAST) begin
                                w_state_nxt = ST_SAVE;
                            end else begin
                                w_idx_nxt = r_idx + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    assign w_user_step = (r_idx > c_IDX_W'(4)) ? 4'd9 : (4'd5 + 4'(r_idx));

    // Passwords never reach the display; only step number and time fields do
    always_comb begin
        bcd_pac = c_BCD_BLANK;
        case (r_state)
            ST_AUTH:     bcd_pac.BCD5 = 4'd0;
            ST_HAB_BIP: begin
                bcd_pac.BCD5 = 4'd1;
                bcd_pac.BCD0 = {3'b000, r_work.bip_status};
            end
            ST_T_BIP: begin
                bcd_pac.BCD5 = 4'd2;
                bcd_pac.BCD1 = bcd_tens(r_work.bip_time);
                bcd_pac.BCD0 = bcd_units(r_work.bip_time);
            end
            ST_T_TRC: begin
                bcd_pac.BCD5 = 4'd3;
                bcd_pac.BCD1 = bcd_tens(r_work.tranca_aut_time);
                bcd_pac.BCD0 = bcd_units(r_work.tranca_aut_time);
            end
            ST_S_MASTER: bcd_pac.BCD5 = 4'd4;
            ST_S_USER:   bcd_pac.BCD5 = w_user_step;
            default: ;
        endcase
    end

    assign display_en     = (r_state != ST_IDLE);
    assign data_setup_ok  = (r_state == ST_SAVE);
    assign setup_abort    = (r_state == ST_ABORT);
    assign setup_err      = r_err;
    assign data_setup_new = r_work;

endmodule
`default_nettype wire

// File: tb/tb_setup_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_setup_param
// Description : Directed self-checking bench for setup_param (2 users,
//               16-cycle inactivity limit).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_setup_param;
    import Tipos::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      setup_on;
    setupPac_t setup_cur;
    senhaPac_t digitos_value;
    logic      digitos_valid;
    logic      display_en;
    bcdPac_t   bcd_pac;
    setupPac_t data_setup_new;
    logic      data_setup_ok;
    logic      setup_abort;
    logic      setup_err;

    int n_pass  = 0;
    int n_total = 0;

    setupPac_t cur;
    setupPac_t alt;
    setupPac_t factory;
    setupPac_t exp_cfg;
    senhaPac_t all_f;
    senhaPac_t all_b;

    setup_param #(
        .N_SENHAS    (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .setup_on       (setup_on),
        .setup_cur      (setup_cur),
        .digitos_value  (digitos_value),
        .digitos_valid  (digitos_valid),
        .display_en     (display_en),
        .bcd_pac        (bcd_pac),
        .data_setup_new (data_setup_new),
        .data_setup_ok  (data_setup_ok),
        .setup_abort    (setup_abort),
        .setup_err      (setup_err)
    );

    always #5 clk = ~clk;

    // n digits typed; low hex nibble of v is the last typed digit
    function automatic senhaPac_t typed(input logic [79:0] v, input int n);
        senhaPac_t s;
        for (int i = 0; i < 20; i++) begin
            s.digits[i] = (i < n) ? v[4*i +: 4] : 4'hF;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic entry(input senhaPac_t v);
        digitos_value = v;
        digitos_valid = 1'b1;
        tick();
        digitos_valid = 1'b0;
        digitos_value = all_f;
    endtask

    task automatic start_session();
        setup_on = 1'b1;
        tick();
        setup_on = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        n_total++;
        if (display_en !== 1'b0) $display("FAIL reset_display_en: got %b want 0", display_en);
        else n_pass++;
        n_total++;
        if (bcd_pac !== 24'hFFFFFF) $display("FAIL reset_bcd: got %h want ffffff", bcd_pac);
        else n_pass++;
        n_total++;
        if (data_setup_new !== factory) $display("FAIL reset_work: got %h want %h", data_setup_new, factory);
        else n_pass++;
        n_total++;
        if ({data_setup_ok, setup_abort, setup_err} !== 3'b000)
            $display("FAIL reset_pulses: got %b want 000", {data_setup_ok, setup_abort, setup_err});
        else n_pass++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_session();
        start_session();
        n_total++;
        if (bcd_pac !== 24'h0FFFFF || display_en !== 1'b1) $display("FAIL basic_auth_disp: got %h/%b want 0fffff/1", bcd_pac, display_en);
        else n_pass++;
        entry(typed(80'h1234, 4));
        n_total++;
        if (bcd_pac !== 24'h1FFFF1) $display("FAIL basic_hab_bip_disp: got %h want 1ffff1", bcd_pac);
        else n_pass++;
        entry(typed(80'h0, 1));
        n_total++;
        if (bcd_pac !== 24'h2FFF20) $display("FAIL basic_t_bip_disp: got %h want 2fff20", bcd_pac);
        else n_pass++;
        entry(typed(80'h07, 2));
        n_total++;
        if (bcd_pac !== 24'h3FFF30 || data_setup_new.bip_time !== 7'd7)
            $display("FAIL basic_t_trc: got %h/%0d want 3fff30/7", bcd_pac, data_setup_new.bip_time);
        else n_pass++;
        entry(typed(80'h99, 2));
        n_total++;
        if (bcd_pac !== 24'h4FFFFF || data_setup_new.tranca_aut_time !== 7'd60)
            $display("FAIL basic_clamp_hi: got %h/%0d want 4fffff/60", bcd_pac, data_setup_new.tranca_aut_time);
        else n_pass++;
        entry(all_b);
        exp_cfg = cur;
        exp_cfg.bip_status = 1'b0;
        exp_cfg.bip_time = 7'd7;
        exp_cfg.tranca_aut_time = 7'd60;
        n_total++;
        if (data_setup_ok !== 1'b1) $display("FAIL basic_ok_pulse: got %b want 1", data_setup_ok);
        else n_pass++;
        n_total++;
        if (data_setup_new !== exp_cfg) $display("FAIL basic_result: got %h want %h", data_setup_new, exp_cfg);
        else n_pass++;
        tick();
        n_total++;
        if (data_setup_ok !== 1'b0 || display_en !== 1'b0)
            $display("FAIL basic_back_idle: got ok=%b disp=%b want 0/0", data_setup_ok, display_en);
        else n_pass++;
    endtask

    task automatic test_lockout();
        start_session();
        for (int k = 0; k < 3; k++) begin
            entry(typed(80'h9999, 4));
            n_total++;
            if (setup_err !== 1'b1) $display("FAIL lockout_err%0d: got %b want 1", k, setup_err);
            else n_pass++;
            n_total++;
            if (setup_abort !== (k == 2)) $display("FAIL lockout_abort%0d: got %b want %b", k, setup_abort, k == 2);
            else n_pass++;
        end
        n_total++;
        if (data_setup_ok !== 1'b0) $display("FAIL lockout_no_ok: got %b want 0", data_setup_ok);
        else n_pass++;
        tick();
        n_total++;
        if (display_en !== 1'b0 || setup_abort !== 1'b0)
            $display("FAIL lockout_idle: got disp=%b abort=%b want 0/0", display_en, setup_abort);
        else n_pass++;
    endtask

    task automatic test_passwords();
        start_session();
        entry(typed(80'h1234, 4));
        entry(all_f);
        entry(all_f);
        entry(all_f);
        n_total++;
        if (bcd_pac !== 24'h4FFFFF) $display("FAIL pw_at_master: got %h want 4fffff", bcd_pac);
        else n_pass++;
        entry(typed(80'h123, 3));
        n_total++;
        if (setup_err !== 1'b1 || bcd_pac !== 24'h4FFFFF) $display("FAIL pw_short: got err=%b disp=%h want 1/4fffff", setup_err, bcd_pac);
        else n_pass++;
        entry(typed(80'h1234567890123, 13));
        n_total++;
        if (setup_err !== 1'b1 || bcd_pac !== 24'h4FFFFF) $display("FAIL pw_long: got err=%b disp=%h want 1/4fffff", setup_err, bcd_pac);
        else n_pass++;
        entry(typed(80'h567890, 6));
        n_total++;
        if (data_setup_new.senha_master !== typed(80'h567890, 6) || setup_err !== 1'b0)
            $display("FAIL pw_master_store: got %h err=%b want %h err=0", data_setup_new.senha_master, setup_err, typed(80'h567890, 6));
        else n_pass++;
        n_total++;
        if (bcd_pac !== 24'h5FFFFF) $display("FAIL pw_user0_disp: got %h want 5fffff", bcd_pac);
        else n_pass++;
        entry(typed(80'h4444, 4));
        n_total++;
        if (bcd_pac !== 24'h6FFFFF) $display("FAIL pw_user1_disp: got %h want 6fffff", bcd_pac);
        else n_pass++;
        entry(typed(80'h5555, 4));
        exp_cfg = cur;
        exp_cfg.senha_master = typed(80'h567890, 6);
        exp_cfg.senha[0] = typed(80'h4444, 4);
        exp_cfg.senha[1] = typed(80'h5555, 4);
        n_total++;
        if (data_setup_ok !== 1'b1) $display("FAIL pw_save_ok: got %b want 1", data_setup_ok);
        else n_pass++;
        n_total++;
        if (data_setup_new !== exp_cfg) $display("FAIL pw_result: got %h want %h", data_setup_new, exp_cfg);
        else n_pass++;
        tick();
    endtask

    task automatic test_timeout();
        start_session();
        entry(typed(80'h1234, 4));
        entry(typed(80'h0, 1));
        for (int k = 0; k < 15; k++) tick();
        n_total++;
        if (setup_abort !== 1'b0 || bcd_pac.BCD5 !== 4'd2) $display("FAIL tmo_before_limit: got abort=%b step=%h want 0/2", setup_abort, bcd_pac.BCD5);
        else n_pass++;
        entry(typed(80'hA, 1));
        n_total++;
        if (setup_abort !== 1'b0 || setup_err !== 1'b1 || bcd_pac.BCD5 !== 4'd2)
            $display("FAIL tmo_valid_wins: got abort=%b err=%b step=%h want 0/1/2", setup_abort, setup_err, bcd_pac.BCD5);
        else n_pass++;
        for (int k = 0; k < 15; k++) tick();
        n_total++;
        if (setup_abort !== 1'b0) $display("FAIL tmo_rearmed: got %b want 0", setup_abort);
        else n_pass++;
        tick();
        n_total++;
        if (setup_abort !== 1'b1 || data_setup_ok !== 1'b0) $display("FAIL tmo_abort: got abort=%b ok=%b want 1/0", setup_abort, data_setup_ok);
        else n_pass++;
        tick();
        n_total++;
        if (display_en !== 1'b0) $display("FAIL tmo_idle: got %b want 0", display_en);
        else n_pass++;
    endtask

    task automatic test_reset_midsession();
        start_session();
        entry(typed(80'h1234, 4));
        for (int k = 0; k < 4; k++) entry(all_f);
        entry(typed(80'h4444, 4));
        n_total++;
        if (bcd_pac !== 24'h6FFFFF) $display("FAIL mid_in_user: got %h want 6fffff", bcd_pac);
        else n_pass++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_total++;
        if (display_en !== 1'b0 || bcd_pac !== 24'hFFFFFF)
            $display("FAIL mid_reset_disp: got %b/%h want 0/ffffff", display_en, bcd_pac);
        else n_pass++;
        n_total++;
        if (data_setup_new !== factory) $display("FAIL mid_reset_work: got %h want %h", data_setup_new, factory);
        else n_pass++;
        n_total++;
        if ({data_setup_ok, setup_abort, setup_err} !== 3'b000)
            $display("FAIL mid_reset_pulses: got %b want 000", {data_setup_ok, setup_abort, setup_err});
        else n_pass++;
        // second request while already in AUTH must not resample the config
        setup_on = 1'b1;
        tick();
        setup_cur = alt;
        tick();
        n_total++;
        if (data_setup_new !== cur || bcd_pac !== 24'h0FFFFF)
            $display("FAIL ignore_setup_on: got bip_time=%0d disp=%h want 20/0fffff", data_setup_new.bip_time, bcd_pac);
        else n_pass++;
        entry(typed(80'h1234, 4));
        setup_on = 1'b0;
        setup_cur = cur;
        entry(all_b);
        n_total++;
        if (data_setup_ok !== 1'b1 || data_setup_new !== cur)
            $display("FAIL ignore_save: got ok=%b bip_time=%0d want 1/20", data_setup_ok, data_setup_new.bip_time);
        else n_pass++;
        tick();
    endtask

    initial begin
        all_f = typed(80'h0, 0);
        all_b = senhaPac_t'({20{4'hB}});
        factory.bip_status      = 1'b1;
        factory.bip_time        = 7'd5;
        factory.tranca_aut_time = 7'd5;
        factory.senha_master    = typed(80'h1234, 4);
        for (int k = 0; k < 8; k++) factory.senha[k] = all_f;
        cur.bip_status      = 1'b1;
        cur.bip_time        = 7'd20;
        cur.tranca_aut_time = 7'd30;
        cur.senha_master    = typed(80'h1234, 4);
        for (int k = 0; k < 8; k++) cur.senha[k] = typed(80'(32'h1111 * (k + 1)), 4);
        alt = cur;
        alt.bip_time = 7'd40;

        rst           = 1'b0;
        setup_on      = 1'b0;
        setup_cur     = cur;
        digitos_value = all_f;
        digitos_valid = 1'b0;

        test_reset();
        test_basic_session();
        test_lockout();
        test_passwords();
        test_timeout();
        test_reset_midsession();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/setup_param.md
# setup_param

Parametrised successor of the lock's configuration menu. On `setup_on` it snapshots the current configuration. It then gates entry behind a master-password check with a retry limit. It walks bip enable, bip time, auto-lock time, the master password and `N_SENHAS` user passwords, using one password state with an index register, and validates each entry. It returns the edited `setupPac_t` with a one-cycle `data_setup_ok`, or aborts on inactivity timeout or lockout. It sits between the keypad digit collector and the main lock FSM / configuration register.

## Interface
- `N_SENHAS`, 4: user passwords edited, 1..`NUM_SENHAS_MAX`.
- `MIN_DIG`, 4: minimum password length in digits.
- `MAX_DIG`, 12: maximum password length in digits, ≤20.
- `T_MIN`, 5: lower clamp for bip and auto-lock times, in seconds.
- `T_MAX`, 60: upper clamp for those times, ≤99.
- `MAX_TRIES`, 3: wrong master entries before lockout.
- `TIMEOUT_CYC`, 30_000_000: inactivity limit in clock cycles.
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-low.
- `setup_on` in 1: request to enter setup; honoured only in IDLE.
- `setup_cur` in `setupPac_t`: live configuration, sampled on entry.
- `digitos_value` in `senhaPac_t`: 20 digits, `digits[0]` is the last typed digit, 4'hF marks an empty position.
- `digitos_valid` in 1: one-cycle strobe qualifying `digitos_value`.
- `display_en` out 1: display owned by this block.
- `bcd_pac` out `bcdPac_t`: display digits BCD0..BCD5.
- `data_setup_new` out `setupPac_t`: working configuration.
- `data_setup_ok` out 1: one-cycle save pulse.
- `setup_abort` out 1: one-cycle pulse on timeout or lockout.
- `setup_err` out 1: one-cycle pulse on a rejected entry.

## Operation
- States: IDLE, AUTH, HAB_BIP, T_BIP, T_TRC, S_MASTER, S_USER (index `idx` 0..N_SENHAS-1), SAVE, ABORT.
- Key decoding:
  - all-F = skip: the field is kept and the FSM advances.
  - all-B = finish: go to SAVE.
  - `len` = number of contiguous non-F digits counted from `digits[0]`.
- IDLE:
  - Outputs idle.
  - On `setup_on`: work ← `setup_cur`, tries ← 0, timer ← 0, next state AUTH.
- AUTH:
  - A valid entry whose non-F digits equal `work.senha_master` digits (F padding identical) goes to HAB_BIP.
  - Any other entry, including all-F or all-B, is a miss: pulse `setup_err` and increment tries.
  - The miss that makes tries reach `MAX_TRIES` goes to ABORT.
- HAB_BIP:
  - `digits[0]` ∈ {0,1} → `bip_status` ← it, next state T_BIP.
  - Otherwise pulse `setup_err` and stay.
- T_BIP and T_TRC:
  - v = 10·d1 + d0, where an F digit counts as 0.
  - d0 or d1 in A..E gives `setup_err` and the FSM stays.
  - Otherwise the field ← clamp(v, `T_MIN`, `T_MAX`) and the FSM advances.
  - Arithmetic is 7-bit unsigned.
- S_MASTER and S_USER:
  - `MIN_DIG` ≤ len ≤ `MAX_DIG` and no digit in A..E within len: store `digits[0..len-1]`, set the remaining digits to F, advance.
  - Otherwise pulse `setup_err` and stay.
  - S_USER increments `idx` on both accept and skip; at `idx`=N_SENHAS-1 it goes to SAVE.
  - Slots ≥ `N_SENHAS` are never written.
- SAVE: `data_setup_ok`=1 for one cycle, then IDLE.
- ABORT: `setup_abort`=1 for one cycle, then IDLE. `data_setup_ok` is not asserted and the work register is discarded.
- Inactivity timer:
  - Counts in every state except IDLE, SAVE and ABORT.
  - Cleared by `digitos_valid`.
  - Reaching `TIMEOUT_CYC`-1 goes to ABORT.
  - If `digitos_valid` arrives in the same cycle, the valid wins.
- Display, outside IDLE:
  - `display_en`=1.
  - BCD5 = step number: AUTH 0, HAB_BIP 1, T_BIP 2, T_TRC 3, S_MASTER 4, S_USER 5+idx (saturating at 9).
  - BCD0 in HAB_BIP = `bip_status`.
  - BCD1:BCD0 in the time steps = tens:units of the working field.
  - All other digits 4'hF; passwords are never shown.
- Ignored inputs:
  - `setup_on` outside IDLE.
  - `digitos_valid` in IDLE, SAVE and ABORT.

## Timing
- Reset (`rst`=0 at a `clk` edge):
  - State IDLE.
  - Work register = factory defaults: bip 1/5/5, master F..F1234, users all-F.
  - All 1-bit outputs 0, `bcd_pac` all F.
  - Counters 0.
  - Reset mid-session discards the session with no pulse.
- Outputs are Moore-decoded from registered state and registers only, with no combinational path from inputs.
- One valid entry advances at most one state; the next state is visible the cycle after the strobe.
- `data_setup_new` is stable throughout SAVE and equals `work` at all times.
- Minimum session: `setup_on`, correct master, then all-B. SAVE is reached 3 edges after `setup_on`.

## Structure
- Package `Tipos` (shared):
  - `senhaPac_t`, `bcdPac_t`, `setupPac_t`, with `setupPac_t` widened to `senha[NUM_SENHAS_MAX]`.
  - `NUM_SENHAS_MAX`=8.
  - `DIG_EMPTY`=4'hF, `DIG_FIM`=4'hB.
  - The factory-default constant.
- Sub-module `setup_digitos_dec` (combinational):
  - Produces `is_skip`, `is_fim`, `len`, `has_bad`, `val2` (two-digit value).
  - Instanced once on `digitos_value`.

## Test plan
- `setup_on`, master 1234, then 0, 07, 99, all-B → `data_setup_ok` pulse. Result: bip_status 0, bip_time 7, tranca_aut_time 60, passwords unchanged.
- Three wrong masters (9999): `setup_err` ×3, then `setup_abort` on the third. No `data_setup_ok`; state IDLE.
- In S_MASTER: 123 (len 3) → `setup_err`, stays. 13 digits → `setup_err`, stays. 567890 → master stored as …FFFF567890.
- With `N_SENHAS`=2: skip through to S_USER and enter 4444 then 5555 → SAVE. senha[0]=4444, senha[1]=5555, senha[2..7] still equal `setup_cur`.
- With `TIMEOUT_CYC`=16: idle for 16 cycles in T_BIP → `setup_abort`. A valid strobe in cycle 15 instead resets the timer with no abort.
- `rst`=0 for one edge while in S_USER → IDLE next cycle, outputs at reset values, no pulses. `setup_on` is ignored while not in IDLE.
